// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream
//   Streaming 3x3 Sobel edge detector. Pixels arrive with vsync/hsync/clken
//   framing. Two line buffers plus the live pixel form the window. Each
//   output carries |Gx|+|Gy| at full precision and an edge bit, which is
//   set when the magnitude is at least the threshold latched for the frame.
//
//   Optional feature macro: SOBEL_DIR_EN (adds quantised gradient direction).
//
//   Handshake: a pixel is transferred on every cycle in which
//   pre_frame_clken is high; there is no back-pressure. post_frame_clken
//   marks each result exactly 3 cycles after its input pixel.
//
// Parameters
//   IMG_WIDTH  active pixels per line (line buffer depth)
//   DATA_W     input pixel width
//   MAG_W      magnitude width, derived as DATA_W+3 (do not override)
//
// Ports
//   clk, rst                         pixel clock, synchronous active-high reset
//   pre_frame_vsync/hsync/clken      input framing
//   pre_img_Y [DATA_W]               input pixel
//   threshold [MAG_W]                edge threshold, latched on vsync rise
//   post_frame_vsync/hsync/clken     framing delayed by 3 cycles
//   post_img_mag [MAG_W]             |Gx|+|Gy|
//   post_img_bit                     post_img_mag >= latched threshold
//   post_img_dir [2]                 gradient direction (0 unless SOBEL_DIR_EN)
module sobel_edge_stream #(
    parameter int IMG_WIDTH = 640,
    parameter int DATA_W    = 8,
    parameter int MAG_W     = DATA_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_clken,
    input  logic [DATA_W-1:0] pre_img_Y,
    input  logic [MAG_W-1:0]  threshold,
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_clken,
    output logic [MAG_W-1:0]  post_img_mag,
    output logic              post_img_bit,
    output logic [1:0]        post_img_dir
);

    localparam int COL_W  = $clog2(IMG_WIDTH + 1);
    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int G_W    = MAG_W + 1;
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);

    // ------------------------------------------------------------------
    // Frame/line tracking
    // ------------------------------------------------------------------
    logic              vs_prev_q, vs_prev_d;
    logic              hs_prev_q, hs_prev_d;
    logic              synced_q, synced_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [MAG_W-1:0]  thr_q, thr_d;
    logic              vs_rise, hs_fall, col_in_range, buf_we;
    logic [ADDR_W-1:0] rd_addr;

    always_comb begin
        vs_rise      = pre_frame_vsync & ~vs_prev_q;
        hs_fall      = ~pre_frame_hsync & hs_prev_q;
        col_in_range = (col_q < COL_LIM);
        rd_addr      = col_in_range ? col_q[ADDR_W-1:0] : '0;
        buf_we       = pre_frame_clken & col_in_range;

        vs_prev_d = pre_frame_vsync;
        hs_prev_d = pre_frame_hsync;
        synced_d  = synced_q;
        col_d     = col_q;
        row_d     = row_q;
        thr_d     = thr_q;

        // Column saturates at IMG_WIDTH: every excess pixel of a long line
        // already falls under the col >= IMG_WIDTH zeroing rule.
        if (hs_fall) begin
            col_d = '0;
        end else if (pre_frame_hsync && pre_frame_clken && col_in_range) begin
            col_d = col_q + 1'b1;
        end

        // Row only needs to distinguish 0, 1 and ">= 2"; vsync rise wins
        // over a simultaneous hsync fall.
        if (vs_rise) begin
            row_d = 2'd0;
        end else if (hs_fall && (row_q != 2'd2)) begin
            row_d = row_q + 2'd1;
        end

        // After a reset, results stay zeroed until a real frame start so a
        // half-seen frame never produces output from misaligned buffers.
        if (vs_rise) begin
            synced_d = 1'b1;
            thr_d    = threshold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // vs_prev resets high so a vsync that is already high when
            // reset lifts is not mistaken for a frame start.
            vs_prev_q <= 1'b1;
            hs_prev_q <= 1'b0;
            synced_q  <= 1'b0;
            col_q     <= '0;
            row_q     <= 2'd0;
            thr_q     <= '1;
        end else begin
            vs_prev_q <= vs_prev_d;
            hs_prev_q <= hs_prev_d;
            synced_q  <= synced_d;
            col_q     <= col_d;
            row_q     <= row_d;
            thr_q     <= thr_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: line1 holds the previous line, line2 the one before.
    // Contents are never cleared; the row < 2 rule masks stale data.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] line1_mem [IMG_WIDTH];
    logic [DATA_W-1:0] line2_mem [IMG_WIDTH];
    logic [DATA_W-1:0] line1_rd, line2_rd;

    assign line1_rd = line1_mem[rd_addr];
    assign line2_rd = line2_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line1_mem[rd_addr] <= pre_img_Y;
            line2_mem[rd_addr] <= line1_rd;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window, win[row][col], row 0 = top, col 2 = newest.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic              zero1_q, zero1_d;

    always_comb begin
        win_d   = win_q;
        zero1_d = zero1_q;
        if (pre_frame_clken) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = line2_rd;
            win_d[1][2] = line1_rd;
            win_d[2][2] = pre_img_Y;
            zero1_d = (row_q < 2'd2) || (col_q < COL_TWO) || !col_in_range || !synced_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q   <= '{default: '0};
            zero1_q <= 1'b1;
        end else begin
            win_q   <= win_d;
            zero1_q <= zero1_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed gradients
    // ------------------------------------------------------------------
    logic signed [G_W-1:0] ext [3][3];
    logic signed [G_W-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                  zero2_q, zero2_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                ext[i][j] = $signed({{(G_W - DATA_W){1'b0}}, win_q[i][j]});
            end
        end
        gx_d = (ext[0][2] + ext[1][2] + ext[1][2] + ext[2][2])
             - (ext[0][0] + ext[1][0] + ext[1][0] + ext[2][0]);
        gy_d = (ext[2][0] + ext[2][1] + ext[2][1] + ext[2][2])
             - (ext[0][0] + ext[0][1] + ext[0][1] + ext[0][2]);
        zero2_d = zero1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q    <= '0;
            gy_q    <= '0;
            zero2_q <= 1'b1;
        end else begin
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            zero2_q <= zero2_d;
        end
    end

    // ------------------------------------------------------------------
    // Framing delay lines (free running)
    // ------------------------------------------------------------------
    logic [2:0] vs_dl_q, vs_dl_d, hs_dl_q, hs_dl_d, ck_dl_q, ck_dl_d;

    always_comb begin
        vs_dl_d = {vs_dl_q[1:0], pre_frame_vsync};
        hs_dl_d = {hs_dl_q[1:0], pre_frame_hsync};
        ck_dl_d = {ck_dl_q[1:0], pre_frame_clken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_dl_q <= '0;
            hs_dl_q <= '0;
            ck_dl_q <= '0;
        end else begin
            vs_dl_q <= vs_dl_d;
            hs_dl_q <= hs_dl_d;
            ck_dl_q <= ck_dl_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, threshold, border zeroing
    // ------------------------------------------------------------------
    logic [MAG_W-1:0] ax, ay, mag_sum;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             bit_q, bit_d;
    logic             out_en;

    always_comb begin
        // |G| <= 4*(2^DATA_W-1), so dropping the sign bit loses nothing.
        ax      = gx_q[G_W-1] ? MAG_W'(-gx_q) : MAG_W'(gx_q);
        ay      = gy_q[G_W-1] ? MAG_W'(-gy_q) : MAG_W'(gy_q);
        mag_sum = ax + ay;
        // ck_dl_q[1] is the clken that loaded the window now in stage 2.
        out_en  = ck_dl_q[1] & ~zero2_q;
        mag_d   = out_en ? mag_sum : '0;
        bit_d   = out_en && (mag_sum >= thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q <= '0;
            bit_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            bit_q <= bit_d;
        end
    end

`ifdef SOBEL_DIR_EN
    logic [1:0]       dir_q, dir_d;
    logic [MAG_W-1:0] ax2, ay2;

    always_comb begin
        ax2   = {ax[MAG_W-2:0], 1'b0};
        ay2   = {ay[MAG_W-2:0], 1'b0};
        dir_d = 2'd0;
        if (out_en) begin
            if (ax >= ay2) begin
                dir_d = 2'd0;
            end else if (ay >= ax2) begin
                dir_d = 2'd1;
            end else if (gx_q[G_W-1] == gy_q[G_W-1]) begin
                // Both gradients are non-zero here, so sign bits compare signs.
                dir_d = 2'd2;
            end else begin
                dir_d = 2'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 2'd0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign post_img_dir = dir_q;
`else
    assign post_img_dir = 2'b00;
`endif

    assign post_frame_vsync = vs_dl_q[2];
    assign post_frame_hsync = hs_dl_q[2];
    assign post_frame_clken = ck_dl_q[2];
    assign post_img_mag     = mag_q;
    assign post_img_bit     = bit_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream
//   Bench for sobel_edge_stream with IMG_WIDTH=8 and 6-line frames. Results
//   are packed as {mag, bit, dir} and queued per frame against expectations.
module tb_sobel_edge_stream;

    localparam int W    = 8;
    localparam int DW   = 8;
    localparam int MW   = DW + 3;
    localparam int H    = 6;
    localparam int MAXC = 12;
    localparam int OW   = MW + 3;
`ifdef SOBEL_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          pre_frame_vsync;
    logic          pre_frame_hsync;
    logic          pre_frame_clken;
    logic [DW-1:0] pre_img_Y;
    logic [MW-1:0] threshold;
    logic          post_frame_vsync;
    logic          post_frame_hsync;
    logic          post_frame_clken;
    logic [MW-1:0] post_img_mag;
    logic          post_img_bit;
    logic [1:0]    post_img_dir;

    sobel_edge_stream #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_clken  (pre_frame_clken),
        .pre_img_Y        (pre_img_Y),
        .threshold        (threshold),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_clken (post_frame_clken),
        .post_img_mag     (post_img_mag),
        .post_img_bit     (post_img_bit),
        .post_img_dir     (post_img_dir)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    bit mon_en    = 1'b0;

    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    logic [DW-1:0] img [H][MAXC];

    // Expected framing: inputs delayed 3 cycles, cleared by reset.
    logic [2:0] hist_q [3];
    always @(posedge clk) begin
        if (rst) begin
            hist_q[0] <= 3'b000;
            hist_q[1] <= 3'b000;
            hist_q[2] <= 3'b000;
        end else begin
            hist_q[0] <= {pre_frame_vsync, pre_frame_hsync, pre_frame_clken};
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            total_cnt++;
            if ({post_frame_vsync, post_frame_hsync, post_frame_clken} !== hist_q[2]) begin
                bad_cnt++;
                $display("FAIL framing_delay t=%0t got=%b exp=%b", $time,
                         {post_frame_vsync, post_frame_hsync, post_frame_clken}, hist_q[2]);
            end
            if (post_frame_clken === 1'b1) begin
                got_q.push_back({post_img_mag, post_img_bit, post_img_dir});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int nlines, input int ncols, input int gap_max,
                               input int thr_line, input logic [MW-1:0] thr_val);
        pre_frame_vsync = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < nlines; r++) begin
            if (r == thr_line) threshold = thr_val;
            pre_frame_hsync = 1'b1;
            tick();
            for (int c = 0; c < ncols; c++) begin
                pre_frame_clken = 1'b1;
                pre_img_Y       = img[r][c];
                tick();
                pre_frame_clken = 1'b0;
                repeat ($urandom_range(gap_max, 0)) tick();
            end
            pre_frame_hsync = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
        pre_frame_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while (got_q.size() < n && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic fill_random(input int ncols);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < ncols; c++)
                img[r][c] = DW'($urandom_range(255, 0));
    endtask

    // Reference Sobel straight from the formula, over the stored image.
    function automatic logic [OW-1:0] model(input int r, input int c, input logic [MW-1:0] thr);
        int p [3][3];
        int gx, gy, ax, ay, mag, dir;
        bit b;
        if (r < 2 || c < 2 || c >= W) return '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = int'(img[r-2+i][c-2+j]);
        gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        ax  = (gx < 0) ? -gx : gx;
        ay  = (gy < 0) ? -gy : gy;
        mag = ax + ay;
        b   = (mag >= int'(thr));
        dir = 0;
        if (DIR_EN) begin
            if (ax >= 2*ay)                   dir = 0;
            else if (ay >= 2*ax)              dir = 1;
            else if ((gx < 0) == (gy < 0))    dir = 2;
            else                              dir = 3;
        end
        return {MW'(mag), b, 2'(dir)};
    endfunction

    function automatic logic [OW-1:0] pk(input int mag, input bit b, input int dir);
        return {MW'(mag), b, 2'(dir)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total_cnt += 6;
        if (post_frame_vsync !== 1'b0) begin bad_cnt++; $display("FAIL reset_vsync got=%b exp=0", post_frame_vsync); end
        if (post_frame_hsync !== 1'b0) begin bad_cnt++; $display("FAIL reset_hsync got=%b exp=0", post_frame_hsync); end
        if (post_frame_clken !== 1'b0) begin bad_cnt++; $display("FAIL reset_clken got=%b exp=0", post_frame_clken); end
        if (post_img_mag !== '0)       begin bad_cnt++; $display("FAIL reset_mag got=%0d exp=0", post_img_mag); end
        if (post_img_bit !== 1'b0)     begin bad_cnt++; $display("FAIL reset_bit got=%b exp=0", post_img_bit); end
        if (post_img_dir !== 2'b00)    begin bad_cnt++; $display("FAIL reset_dir got=%0d exp=0", post_img_dir); end
        rst = 1'b0;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_flat();
        logic [OW-1:0] e, g;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd100;
        for (int i = 0; i < H*W; i++) exp_q.push_back('0);
        threshold = 11'd1;
        drive_frame(H, W, 0, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != 48) begin bad_cnt++; $display("FAIL flat_count got=%0d exp=48", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL flat_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_vstep();
        logic [OW-1:0] e, g;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 8'd255 : 8'd0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
            exp_q.push_back((r >= 2 && (c == 4 || c == 5)) ? pk(1020, 1'b1, 0) : '0);
        threshold = 11'd500;
        drive_frame(H, W, 0, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL vstep_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL vstep_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_hstep();
        logic [OW-1:0] e, g;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r >= 3) ? 8'd255 : 8'd0;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
            exp_q.push_back(((r == 3 || r == 4) && c >= 2) ? pk(1020, 1'b1, DIR_EN ? 1 : 0) : '0);
        threshold = 11'd1;
        drive_frame(H, W, 1, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL hstep_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL hstep_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // Ramps of slope 16 per pixel: |Gx| = |Gy| = 128, mag = 256.
    task automatic test_diag();
        logic [OW-1:0] e, g;
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
                img[r][c] = DW'((pass == 0) ? (r + c) * 16 : (r + 7 - c) * 16);
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++)
                exp_q.push_back((r >= 2 && c >= 2) ? pk(256, 1'b1, DIR_EN ? (pass == 0 ? 2 : 3) : 0) : '0);
            threshold = 11'd1;
            drive_frame(H, W, 0, -1, '0);
            wait_drain(exp_q.size());
            total_cnt++;
            if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL diag%0d_count got=%0d exp=%0d", pass, got_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
                if (g !== e) begin bad_cnt++; $display("FAIL diag%0d_pix got=%h exp=%h", pass, g, e); end
            end
            exp_q.delete(); got_q.delete();
        end
    endtask

    task automatic test_gaps();
        logic [OW-1:0] e, g;
        fill_random(W);
        threshold = 11'd300;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) exp_q.push_back(model(r, c, 11'd300));
        drive_frame(H, W, 5, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL gaps_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL gaps_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_long_line();
        logic [OW-1:0] e, g;
        fill_random(10);
        threshold = 11'd200;
        for (int r = 0; r < H; r++) for (int c = 0; c < 10; c++) exp_q.push_back(model(r, c, 11'd200));
        drive_frame(H, 10, 1, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != 60) begin bad_cnt++; $display("FAIL long_count got=%0d exp=60", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL long_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_threshold();
        logic [OW-1:0] e, g;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c >= 4) ? 8'd255 : 8'd0;
        for (int f = 0; f < 2; f++) begin
            // Frame 0 keeps threshold 1020 despite the change on line 2;
            // frame 1 starts with threshold 0, so every interior pixel is an edge.
            for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) begin
                if (r >= 2 && (c == 4 || c == 5))  exp_q.push_back(pk(1020, 1'b1, 0));
                else if (f == 1 && r >= 2 && c >= 2) exp_q.push_back(pk(0, 1'b1, 0));
                else                                 exp_q.push_back('0);
            end
            if (f == 0) threshold = 11'd1020;
            drive_frame(H, W, 0, (f == 0) ? 2 : -1, 11'd0);
            wait_drain(exp_q.size());
            total_cnt++;
            if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL thr%0d_count got=%0d exp=%0d", f, got_q.size(), exp_q.size()); end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
                if (g !== e) begin bad_cnt++; $display("FAIL thr%0d_pix got=%h exp=%h", f, g, e); end
            end
            exp_q.delete(); got_q.delete();
        end
    endtask

    task automatic test_rst_mid();
        logic [OW-1:0] e, g;
        fill_random(W);
        threshold = 11'd1;
        pre_frame_vsync = 1'b1;
        repeat (2) tick();
        for (int r = 0; r < 3; r++) begin
            pre_frame_hsync = 1'b1;
            tick();
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 3) break;
                pre_frame_clken = 1'b1;
                pre_img_Y       = img[r][c];
                tick();
                pre_frame_clken = 1'b0;
            end
            if (r < 2) begin
                pre_frame_hsync = 1'b0;
                repeat (3) tick();
            end
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt += 3;
            if (post_frame_clken !== 1'b0) begin bad_cnt++; $display("FAIL rstmid_clken%0d got=%b exp=0", k, post_frame_clken); end
            if (post_img_mag !== '0)       begin bad_cnt++; $display("FAIL rstmid_mag%0d got=%0d exp=0", k, post_img_mag); end
            if (post_img_bit !== 1'b0)     begin bad_cnt++; $display("FAIL rstmid_bit%0d got=%b exp=0", k, post_img_bit); end
        end
        rst = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_vsync = 1'b0;
        repeat (10) tick();
        got_q.delete();
        fill_random(W);
        threshold = 11'd400;
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) exp_q.push_back(model(r, c, 11'd400));
        drive_frame(H, W, 2, -1, '0);
        wait_drain(exp_q.size());
        total_cnt++;
        if (got_q.size() != exp_q.size()) begin bad_cnt++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total_cnt++;
            if (g !== e) begin bad_cnt++; $display("FAIL rstmid_pix got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst             = 1'b1;
        pre_frame_vsync = 1'b0;
        pre_frame_hsync = 1'b0;
        pre_frame_clken = 1'b0;
        pre_img_Y       = '0;
        threshold       = '0;
        test_reset();
        test_flat();
        test_vstep();
        test_hstep();
        test_diag();
        test_gaps();
        test_long_line();
        test_threshold();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
